// File: rtl/alu_div_seq.sv
// alu_div_seq: 8-bit unsigned restoring divider, one quotient bit per cycle.
// Divide-by-zero short-circuits straight to DONE with a saturated quotient.
module alu_div_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_qreg;
  logic [7:0]  r_dvsr;
  logic [8:0]  r_part;
  logic [2:0]  r_cnt;
  logic [7:0]  r_quot;
  logic [7:0]  r_rem;
  logic        r_dbz;

  logic        w_accept;
  logic        w_zero;
  logic        w_last;
  logic [8:0]  w_shift;
  logic        w_ge;
  logic [8:0]  w_part_n;
  logic [7:0]  w_qreg_n;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_zero   = (divisor == 8'd0);
  assign w_last   = (r_cnt == 3'd7);

  // One restoring step: bring in the next dividend bit, try the subtract.
  assign w_shift  = {r_part[7:0], r_qreg[7]};
  assign w_ge     = (w_shift >= {1'b0, r_dvsr});
  assign w_part_n = w_ge ? (w_shift - {1'b0, r_dvsr}) : w_shift;
  assign w_qreg_n = {r_qreg[6:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_qreg <= 8'd0;
      r_dvsr <= 8'd0;
      r_part <= 9'd0;
      r_cnt  <= 3'd0;
      r_quot <= 8'd0;
      r_rem  <= 8'd0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_zero) begin
          r_quot <= 8'hFF;
          r_rem  <= dividend;
          r_dbz  <= 1'b1;
        end else begin
          r_qreg <= dividend;
          r_dvsr <= divisor;
          r_part <= 9'd0;
          r_cnt  <= 3'd0;
        end
      end else if (r_state == S_CALC) begin
        r_qreg <= w_qreg_n;
        r_part <= w_part_n;
        r_cnt  <= r_cnt + 3'd1;
        if (w_last) begin
          r_quot <= w_qreg_n;
          r_rem  <= w_part_n[7:0];
          r_dbz  <= 1'b0;
        end
      end
    end
  end

  assign busy        = (r_state == S_CALC);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: vector table, corner sequences and random sweep
// against a plain-arithmetic division model.
module tb_alu_div_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_cmp;
  int n_err;

  alu_div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Launch one division and check results, latency and busy length.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic ez, input string nm);
    int edges;
    int bcnt;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    edges = 1;
    bcnt  = 0;
    while (!done && edges < 20) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    chk({nm, " latency"}, edges, (b == 0) ? 1 : 9);
    chk({nm, " busy_cycles"}, bcnt, (b == 0) ? 0 : 8);
    chk({nm, " quotient"}, int'(quotient), int'(eq));
    chk({nm, " remainder"}, int'(remainder), int'(er));
    chk({nm, " div_by_zero"}, int'(div_by_zero), int'(ez));
    if (b != 0) begin
      chk({nm, " invariant"}, int'(quotient) * int'(b) + int'(remainder),
          int'(a));
      chk({nm, " rem_lt_div"}, int'(remainder < b), 1);
    end
    @(posedge clk);
    #1;
    chk({nm, " done_pulse"}, int'(done), 0);
  endtask

  initial begin
    vec_t tbl[6];
    int   dcnt;
    int   cyc;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] hq;

    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;

    tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    tbl[3] = '{8'd42,  8'd0,   8'hFF,  8'd42, 1'b1};
    tbl[4] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
    tbl[5] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset quotient", int'(quotient), 0);
    chk("reset remainder", int'(remainder), 0);
    chk("reset dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z,
             $sformatf("vec%0d", i));
    end

    // Outputs hold between operations.
    hq = quotient;
    repeat (5) @(posedge clk);
    #1;
    chk("hold quotient", int'(quotient), int'(hq));

    // Start pulse during CALC is ignored.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 8'd10;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("ignore_start done_count", dcnt, 1);
    chk("ignore_start quotient", int'(quotient), 66);
    chk("ignore_start remainder", int'(remainder), 2);

    // Reset mid-CALC aborts without a done pulse.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort quotient", int'(quotient), 0);
    chk("abort remainder", int'(remainder), 0);
    chk("abort dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("abort no_done", dcnt, 0);
    run_op(8'd9, 8'd4, 8'd2, 8'd1, 1'b0, "after_abort");

    // Start held high: one idle cycle, then relaunch.
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd7;
    start    = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("b2b first_done", int'(done), 1);
    @(posedge clk);
    #1;
    chk("b2b idle_gap busy", int'(busy), 0);
    chk("b2b idle_gap done", int'(done), 0);
    @(posedge clk);
    #1;
    chk("b2b relaunch busy", int'(busy), 1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("b2b second_done", int'(done), 1);
    chk("b2b quotient", int'(quotient), 7);
    chk("b2b remainder", int'(remainder), 1);
    @(posedge clk);

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (rb == 0) begin
        run_op(ra, rb, 8'hFF, ra, 1'b1, $sformatf("rnd%0d", i));
      end else begin
        run_op(ra, rb, ra / rb, ra % rb, 1'b0, $sformatf("rnd%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
